// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: req/ack data-memory access with wait states and timeout,
// branch resolution, upstream stall generation and the MEM/WB register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter bit          ALIGN_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ZERO_MEM,
  input  logic [31:0] ALU_OUT_MEM,
  input  logic [31:0] PC_Branch_MEM,
  input  logic [31:0] REG_DATA2_MEM_FINAL,
  input  logic [4:0]  RD_MEM,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic        Branch_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_mem,
  output logic        PCSrc,
  output logic [31:0] PC_Branch_out,
  output logic [31:0] READ_DATA_WB,
  output logic [31:0] ALU_OUT_WB,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic        bus_err,
  output logic        mis_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic        mis_err_q, mis_err_d;
  logic [31:0] read_data_wb_q, read_data_wb_d;
  logic [31:0] alu_out_wb_q, alu_out_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic        regwrite_wb_q, regwrite_wb_d;
  logic        memtoreg_wb_q, memtoreg_wb_d;

  logic access, aligned, at_last;

  assign access  = MemRead_MEM | MemWrite_MEM;
  assign aligned = !ALIGN_CHECK || (ALU_OUT_MEM[1:0] == 2'b00);
  assign at_last = (cnt_q == CNT_LAST);

  assign stall_mem = ((state_q == IDLE) && access && aligned) ||
                     ((state_q == WAIT_ACK) && !mem_ack && !at_last);
  assign PCSrc         = Branch_MEM & ZERO_MEM & ~stall_mem;
  assign PC_Branch_out = PC_Branch_MEM;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    bus_err_d      = 1'b0;
    mis_err_d      = 1'b0;
    // Default MEM/WB content is a bubble; only retiring instructions overwrite it.
    read_data_wb_d = '0;
    alu_out_wb_d   = '0;
    rd_wb_d        = '0;
    regwrite_wb_d  = 1'b0;
    memtoreg_wb_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (access && aligned) begin
          mem_req_d   = 1'b1;
          mem_we_d    = MemWrite_MEM;
          mem_addr_d  = ALU_OUT_MEM;
          mem_wdata_d = REG_DATA2_MEM_FINAL;
          cnt_d       = '0;
          state_d     = WAIT_ACK;
        end else if (access) begin
          mis_err_d = 1'b1;
        end else begin
          alu_out_wb_d  = ALU_OUT_MEM;
          rd_wb_d       = RD_MEM;
          regwrite_wb_d = RegWrite_MEM;
          memtoreg_wb_d = MemtoReg_MEM;
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          mem_req_d      = 1'b0;
          state_d        = IDLE;
          cnt_d          = '0;
          read_data_wb_d = mem_rdata;
          alu_out_wb_d   = ALU_OUT_MEM;
          rd_wb_d        = RD_MEM;
          // Combined read+write performs only the write, so nothing is written back.
          regwrite_wb_d  = RegWrite_MEM & ~(MemRead_MEM & MemWrite_MEM);
          memtoreg_wb_d  = MemtoReg_MEM;
        end else if (at_last) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      bus_err_q      <= 1'b0;
      mis_err_q      <= 1'b0;
      read_data_wb_q <= '0;
      alu_out_wb_q   <= '0;
      rd_wb_q        <= '0;
      regwrite_wb_q  <= 1'b0;
      memtoreg_wb_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      bus_err_q      <= bus_err_d;
      mis_err_q      <= mis_err_d;
      read_data_wb_q <= read_data_wb_d;
      alu_out_wb_q   <= alu_out_wb_d;
      rd_wb_q        <= rd_wb_d;
      regwrite_wb_q  <= regwrite_wb_d;
      memtoreg_wb_q  <= memtoreg_wb_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign bus_err      = bus_err_q;
  assign mis_err      = mis_err_q;
  assign READ_DATA_WB = read_data_wb_q;
  assign ALU_OUT_WB   = alu_out_wb_q;
  assign RD_WB        = rd_wb_q;
  assign RegWrite_WB  = regwrite_wb_q;
  assign MemtoReg_WB  = memtoreg_wb_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table for single-cycle IDLE cases,
// hand-written sequences for load/store/timeout/reset/no-align-check.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset1;
  logic        ZERO_MEM, RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM;
  logic [31:0] ALU_OUT_MEM, PC_Branch_MEM, REG_DATA2_MEM_FINAL, mem_rdata;
  logic [4:0]  RD_MEM;
  logic        mem_ack;

  logic        mem_req, mem_we, stall_mem, PCSrc, RegWrite_WB, MemtoReg_WB, bus_err, mis_err;
  logic [31:0] mem_addr, mem_wdata, PC_Branch_out, READ_DATA_WB, ALU_OUT_WB;
  logic [4:0]  RD_WB;

  logic        u1_req, u1_we, u1_stall, u1_pcsrc, u1_rw, u1_m2r, u1_berr, u1_merr;
  logic [31:0] u1_addr, u1_wdata, u1_pcb, u1_rdata_wb, u1_alu_wb;
  logic [4:0]  u1_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(16), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .ZERO_MEM(ZERO_MEM), .ALU_OUT_MEM(ALU_OUT_MEM),
    .PC_Branch_MEM(PC_Branch_MEM), .REG_DATA2_MEM_FINAL(REG_DATA2_MEM_FINAL), .RD_MEM(RD_MEM),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .MemRead_MEM(MemRead_MEM),
    .MemWrite_MEM(MemWrite_MEM), .Branch_MEM(Branch_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_mem(stall_mem), .PCSrc(PCSrc),
    .PC_Branch_out(PC_Branch_out), .READ_DATA_WB(READ_DATA_WB), .ALU_OUT_WB(ALU_OUT_WB),
    .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
    .bus_err(bus_err), .mis_err(mis_err)
  );

  mem_stage_ctrl #(.TIMEOUT_CYCLES(16), .ALIGN_CHECK(1'b0)) u1 (
    .clk(clk), .reset(reset1), .ZERO_MEM(ZERO_MEM), .ALU_OUT_MEM(ALU_OUT_MEM),
    .PC_Branch_MEM(PC_Branch_MEM), .REG_DATA2_MEM_FINAL(REG_DATA2_MEM_FINAL), .RD_MEM(RD_MEM),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .MemRead_MEM(MemRead_MEM),
    .MemWrite_MEM(MemWrite_MEM), .Branch_MEM(Branch_MEM),
    .mem_req(u1_req), .mem_we(u1_we), .mem_addr(u1_addr), .mem_wdata(u1_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_mem(u1_stall), .PCSrc(u1_pcsrc),
    .PC_Branch_out(u1_pcb), .READ_DATA_WB(u1_rdata_wb), .ALU_OUT_WB(u1_alu_wb),
    .RD_WB(u1_rd), .RegWrite_WB(u1_rw), .MemtoReg_WB(u1_m2r),
    .bus_err(u1_berr), .mis_err(u1_merr)
  );

  typedef struct {
    logic        br, zr, mr, mw, rw, m2r;
    logic [31:0] alu, pcb;
    logic [4:0]  rd;
    logic        e_stall, e_pcsrc, e_rw, e_mis;
    logic [31:0] e_alu;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    ZERO_MEM = 0; RegWrite_MEM = 0; MemtoReg_MEM = 0; MemRead_MEM = 0;
    MemWrite_MEM = 0; Branch_MEM = 0; ALU_OUT_MEM = '0; PC_Branch_MEM = '0;
    REG_DATA2_MEM_FINAL = '0; RD_MEM = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    bit seen;

    //           br zr mr mw rw m2r alu           pcb          rd  st pc rw mis e_alu         e_rd
    vecs[0] = '{1, 1, 0, 0, 0, 0, 32'h0,        32'h200,     5'd0,  0, 1, 0, 0, 32'h0,        5'd0};
    vecs[1] = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h300,     5'd0,  0, 0, 0, 0, 32'h0,        5'd0};
    vecs[2] = '{0, 0, 0, 0, 1, 0, 32'hCAFE0001, 32'h0,       5'd7,  0, 0, 1, 0, 32'hCAFE0001, 5'd7};
    vecs[3] = '{0, 0, 1, 0, 1, 1, 32'h102,      32'h0,       5'd3,  0, 0, 0, 1, 32'h0,        5'd0};
    vecs[4] = '{1, 1, 0, 1, 0, 0, 32'h41,       32'h480,     5'd0,  0, 1, 0, 1, 32'h0,        5'd0};
    vecs[5] = '{0, 0, 0, 0, 1, 0, 32'h12345678, 32'h0,       5'd31, 0, 0, 1, 0, 32'h12345678, 5'd31};

    clear_in();
    reset = 0; reset1 = 0; mem_ack = 0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_regwrite_wb", 32'(RegWrite_WB), 0);
    chk("rst_alu_wb", ALU_OUT_WB, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_mis_err", 32'(mis_err), 0);
    reset = 1;

    for (int i = 0; i < 6; i++) begin
      Branch_MEM = vecs[i].br; ZERO_MEM = vecs[i].zr; MemRead_MEM = vecs[i].mr;
      MemWrite_MEM = vecs[i].mw; RegWrite_MEM = vecs[i].rw; MemtoReg_MEM = vecs[i].m2r;
      ALU_OUT_MEM = vecs[i].alu; PC_Branch_MEM = vecs[i].pcb; RD_MEM = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_mem), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_pcsrc", i), 32'(PCSrc), 32'(vecs[i].e_pcsrc));
      chk($sformatf("v%0d_pcb_out", i), PC_Branch_out, vecs[i].pcb);
      step();
      chk($sformatf("v%0d_alu_wb", i), ALU_OUT_WB, vecs[i].e_alu);
      chk($sformatf("v%0d_rd_wb", i), 32'(RD_WB), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_rw_wb", i), 32'(RegWrite_WB), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_mis_err", i), 32'(mis_err), 32'(vecs[i].e_mis));
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 0);
      chk($sformatf("v%0d_rdata_wb", i), READ_DATA_WB, 0);
    end
    clear_in();
    step();
    chk("mis_err_one_cycle", 32'(mis_err), 0);

    // Load with three wait cycles
    MemRead_MEM = 1; ALU_OUT_MEM = 32'h100; RD_MEM = 5; RegWrite_MEM = 1; MemtoReg_MEM = 1;
    stalls = 0;
    #1; if (stall_mem) stalls++;
    step();
    chk("ld_req", 32'(mem_req), 1);
    chk("ld_addr", mem_addr, 32'h100);
    chk("ld_we", 32'(mem_we), 0);
    chk("ld_bubble", 32'(RegWrite_WB), 0);
    for (int i = 0; i < 3; i++) begin
      #1; if (stall_mem) stalls++;
      step();
      chk("ld_req_held", 32'(mem_req), 1);
    end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    #1; if (stall_mem) stalls++;
    step();
    mem_ack = 0; mem_rdata = '0;
    clear_in();
    chk("ld_stall_cycles", 32'(stalls), 4);
    chk("ld_rdata_wb", READ_DATA_WB, 32'hDEADBEEF);
    chk("ld_rd_wb", 32'(RD_WB), 5);
    chk("ld_rw_wb", 32'(RegWrite_WB), 1);
    chk("ld_m2r_wb", 32'(MemtoReg_WB), 1);
    chk("ld_req_drop", 32'(mem_req), 0);
    step();
    chk("ld_single_wb", 32'(RegWrite_WB), 0);

    // Store with zero-wait ack
    MemWrite_MEM = 1; ALU_OUT_MEM = 32'h44; REG_DATA2_MEM_FINAL = 32'h12345678;
    stalls = 0;
    #1; if (stall_mem) stalls++;
    step();
    chk("st_req", 32'(mem_req), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_addr", mem_addr, 32'h44);
    chk("st_wdata", mem_wdata, 32'h12345678);
    mem_ack = 1;
    #1; if (stall_mem) stalls++;
    step();
    mem_ack = 0;
    clear_in();
    chk("st_stall_cycles", 32'(stalls), 1);
    chk("st_rw_wb", 32'(RegWrite_WB), 0);
    chk("st_req_drop", 32'(mem_req), 0);

    // Read+write together: write wins, no writeback
    MemRead_MEM = 1; MemWrite_MEM = 1; RegWrite_MEM = 1; ALU_OUT_MEM = 32'h48; RD_MEM = 8;
    step();
    chk("rw_we", 32'(mem_we), 1);
    mem_ack = 1; mem_rdata = 32'h55AA55AA;
    step();
    mem_ack = 0;
    clear_in();
    chk("rw_no_wb", 32'(RegWrite_WB), 0);

    // Timeout: ack never comes
    MemRead_MEM = 1; ALU_OUT_MEM = 32'h200; RD_MEM = 9; RegWrite_MEM = 1;
    stalls = 0; seen = 0;
    for (int n = 0; n < 40; n++) begin
      #1; if (stall_mem) stalls++;
      step();
      if (bus_err) begin seen = 1; break; end
    end
    chk("to_bus_err_seen", 32'(seen), 1);
    chk("to_stall_cycles", 32'(stalls), 16);
    chk("to_req_drop", 32'(mem_req), 0);
    chk("to_bubble", 32'(RegWrite_WB), 0);
    clear_in();
    ALU_OUT_MEM = 32'h55; RD_MEM = 2; RegWrite_MEM = 1;
    #1;
    chk("to_next_nostall", 32'(stall_mem), 0);
    step();
    chk("to_bus_err_pulse", 32'(bus_err), 0);
    chk("to_next_alu_wb", ALU_OUT_WB, 32'h55);
    chk("to_next_rw_wb", 32'(RegWrite_WB), 1);

    // ALIGN_CHECK=0 instance issues the misaligned access
    clear_in();
    reset1 = 1;
    MemRead_MEM = 1; ALU_OUT_MEM = 32'h102; RD_MEM = 3; RegWrite_MEM = 1;
    #1;
    chk("na_stall", 32'(u1_stall), 1);
    chk("ac_nostall", 32'(stall_mem), 0);
    step();
    chk("na_req", 32'(u1_req), 1);
    chk("na_addr", u1_addr, 32'h102);
    chk("ac_mis_err", 32'(mis_err), 1);
    chk("ac_no_req", 32'(mem_req), 0);
    clear_in();
    mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    mem_ack = 0;
    chk("na_rdata_wb", u1_rdata_wb, 32'hA5A5A5A5);
    chk("na_req_drop", 32'(u1_req), 0);
    chk("ac_ack_ignored", READ_DATA_WB, 0);
    reset1 = 0;

    // Reset in the middle of WAIT_ACK
    MemRead_MEM = 1; ALU_OUT_MEM = 32'h300; RD_MEM = 4; RegWrite_MEM = 1;
    step();
    chk("rw_req_up", 32'(mem_req), 1);
    step();
    reset = 0;
    step();
    chk("rm_req_drop", 32'(mem_req), 0);
    step();
    chk("rm_rw_wb", 32'(RegWrite_WB), 0);
    clear_in();
    ALU_OUT_MEM = 32'h77;
    reset = 1;
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("rm_nostall", 32'(stall_mem), 0);
    step();
    mem_ack = 0;
    chk("rm_late_ack_rdata", READ_DATA_WB, 0);
    chk("rm_late_ack_rw", 32'(RegWrite_WB), 0);
    chk("rm_late_ack_req", 32'(mem_req), 0);
    chk("rm_alu_wb", ALU_OUT_WB, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
